// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit saturating direction counters.
// Optional BP_STATS_EN macro adds branch and mispredict statistics outputs.
`default_nettype none

module branch_predictor #(
    parameter int IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_if,
    output logic        branch_predict,
    output logic [31:0] predict_target,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_predicted,
    input  logic [31:0] ex_pred_target,
`ifdef BP_STATS_EN
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts,
`endif
    output logic        predict_outcome
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = 32 - IDX_W - 2;

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];
    logic [1:0]         r_ctr    [ENTRIES];

    logic [IDX_W-1:0]   w_if_idx;
    logic [TAG_W-1:0]   w_if_tag;
    logic               w_if_hit;
    logic [IDX_W-1:0]   w_ex_idx;
    logic [TAG_W-1:0]   w_ex_tag;
    logic               w_ex_hit;
    logic               w_upd;
    logic [1:0]         w_ctr_next;

    assign w_if_idx = pc_if[IDX_W+1:2];
    assign w_if_tag = pc_if[31:IDX_W+2];
    assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);

    assign branch_predict = w_if_hit && r_ctr[w_if_idx][1];
    assign predict_target = w_if_hit ? r_target[w_if_idx] : 32'h0;

    assign w_ex_idx = ex_pc[IDX_W+1:2];
    assign w_ex_tag = ex_pc[31:IDX_W+2];
    assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
    assign w_upd    = ex_valid && ex_is_branch;

    assign predict_outcome = !(w_upd &&
                               ((ex_predicted != ex_taken) ||
                                (ex_taken && (ex_pred_target != ex_target))));

    always_comb begin
        w_ctr_next = r_ctr[w_ex_idx];
        if (ex_taken) begin
            if (r_ctr[w_ex_idx] != 2'b11)
                w_ctr_next = r_ctr[w_ex_idx] + 2'b01;
        end else begin
            if (r_ctr[w_ex_idx] != 2'b00)
                w_ctr_next = r_ctr[w_ex_idx] - 2'b01;
        end
    end

    // Not-taken misses are never allocated, so cold branches stay out of the table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= 32'h0;
                r_ctr[i]    <= 2'b01;
            end
        end else if (w_upd) begin
            if (w_ex_hit) begin
                r_ctr[w_ex_idx] <= w_ctr_next;
                if (ex_taken)
                    r_target[w_ex_idx] <= ex_target;
            end else if (ex_taken) begin
                r_valid[w_ex_idx]  <= 1'b1;
                r_tag[w_ex_idx]    <= w_ex_tag;
                r_target[w_ex_idx] <= ex_target;
                r_ctr[w_ex_idx]    <= 2'b10;
            end
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_mispredicts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_branches    <= 32'h0;
            r_stat_mispredicts <= 32'h0;
        end else begin
            if (w_upd)
                r_stat_branches <= r_stat_branches + 32'h1;
            if (!predict_outcome)
                r_stat_mispredicts <= r_stat_mispredicts + 32'h1;
        end
    end

    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: vector table, directed sequences and random traffic
// against a behavioural table model of the branch predictor.
`default_nettype none

module tb_branch_predictor;

    localparam int IDX_W   = 4;
    localparam int ENTRIES = 1 << IDX_W;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_if = 32'h0;
    logic        branch_predict;
    logic [31:0] predict_target;
    logic        ex_valid = 1'b0;
    logic        ex_is_branch = 1'b0;
    logic [31:0] ex_pc = 32'h0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_target = 32'h0;
    logic        ex_predicted = 1'b0;
    logic [31:0] ex_pred_target = 32'h0;
    logic        predict_outcome;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    always #5 clk = ~clk;

    branch_predictor #(.IDX_W(IDX_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_if          (pc_if),
        .branch_predict (branch_predict),
        .predict_target (predict_target),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_predicted   (ex_predicted),
        .ex_pred_target (ex_pred_target),
`ifdef BP_STATS_EN
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts),
`endif
        .predict_outcome(predict_outcome)
    );

    // Reference model: one record per slot, keyed by the full PC that owns it.
    bit          m_valid [ENTRIES];
    int unsigned m_owner [ENTRIES];
    int unsigned m_tgt   [ENTRIES];
    int          m_conf  [ENTRIES];
    int unsigned exp_branches;
    int unsigned exp_mispredicts;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%h required=%h", nm, act, req);
    endtask

    function automatic int slot(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic bit same_line(input logic [31:0] a, input logic [31:0] b);
        return (a >> (IDX_W + 2)) == (b >> (IDX_W + 2));
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[slot(pc)] && same_line(m_owner[slot(pc)], pc);
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_hit(pc) && (m_conf[slot(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_target(input logic [31:0] pc);
        return m_hit(pc) ? m_tgt[slot(pc)] : 32'h0;
    endfunction

    function automatic bit m_outcome();
        if (!(ex_valid && ex_is_branch)) return 1'b1;
        if (ex_predicted != ex_taken) return 1'b0;
        if (ex_taken && ex_pred_target != ex_target) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_owner[i] = 0; m_tgt[i] = 0; m_conf[i] = 1;
        end
        exp_branches = 0;
        exp_mispredicts = 0;
    endtask

    task automatic m_update();
        int s;
        s = slot(ex_pc);
        if (!m_outcome()) exp_mispredicts++;
        if (ex_valid && ex_is_branch) begin
            exp_branches++;
            if (m_hit(ex_pc)) begin
                m_conf[s] = ex_taken ? ((m_conf[s] + 1 > 3) ? 3 : m_conf[s] + 1)
                                     : ((m_conf[s] - 1 < 0) ? 0 : m_conf[s] - 1);
                if (ex_taken) m_tgt[s] = ex_target;
            end else if (ex_taken) begin
                m_valid[s] = 1; m_owner[s] = ex_pc; m_tgt[s] = ex_target; m_conf[s] = 2;
            end
        end
    endtask

    task automatic drive(input logic [31:0] pif, input logic v, input logic br,
                         input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                         input logic pr, input logic [31:0] pt);
        pc_if = pif; ex_valid = v; ex_is_branch = br; ex_pc = pc;
        ex_taken = tk; ex_target = tg; ex_predicted = pr; ex_pred_target = pt;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) m_update();
        @(negedge clk);
    endtask

    task automatic lookup(input string nm, input logic [31:0] pc, input logic ebp, input logic [31:0] etg);
        drive(pc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check({nm, "_bp"}, {31'h0, branch_predict}, {31'h0, ebp});
        check({nm, "_tgt"}, predict_target, etg);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Branch update at 0x40 with a chosen direction, lookup held at 0x40.
    task automatic upd40(input logic tk);
        drive(32'h40, 1'b1, 1'b1, 32'h40, tk, 32'h100, 1'b0, 32'h0);
        tick();
    endtask

    typedef struct {
        logic        v, br, tk, pr;
        logic [31:0] pt, tg;
        logic        exp_out;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   32'h100, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0,   32'h10,  1'b1};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 32'h100, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 32'h104, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h55,  32'h66,  1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h100, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   32'h200, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h1,   32'h2,   1'b1};

        m_reset();
        @(negedge clk);
        drive(32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("in_reset_bp", {31'h0, branch_predict}, 32'h0);
        do_reset();

        lookup("reset_lookup", 32'h40, 1'b0, 32'h0);

        // Allocation with lookup to the same slot in the same cycle: no bypass.
        drive(32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        check("alloc_outcome", {31'h0, predict_outcome}, 32'h0);
        check("alloc_same_cycle_bp", {31'h0, branch_predict}, 32'h0);
        tick();
        lookup("alloc_next", 32'h40, 1'b1, 32'h100);

        upd40(1'b0); lookup("nt1", 32'h40, 1'b0, 32'h100);
        upd40(1'b0); lookup("nt2", 32'h40, 1'b0, 32'h100);
        upd40(1'b0); lookup("nt3_sat", 32'h40, 1'b0, 32'h100);
        upd40(1'b1); lookup("tk1", 32'h40, 1'b0, 32'h100);
        upd40(1'b1); lookup("tk2", 32'h40, 1'b1, 32'h100);
        upd40(1'b1); lookup("tk3", 32'h40, 1'b1, 32'h100);
        upd40(1'b1); lookup("tk4_sat", 32'h40, 1'b1, 32'h100);
        upd40(1'b0); lookup("nt_after_sat", 32'h40, 1'b1, 32'h100);

        drive(32'h0, 1'b1, 1'b1, 32'h80, 1'b1, 32'h200, 1'b0, 32'h0);
        tick();
        lookup("alias_old", 32'h40, 1'b0, 32'h0);
        lookup("alias_new", 32'h80, 1'b1, 32'h200);

        drive(32'h0, 1'b1, 1'b1, 32'h140, 1'b0, 32'h999, 1'b0, 32'h0);
        tick();
        lookup("nt_miss_noalloc", 32'h80, 1'b1, 32'h200);

        drive(32'h0, 1'b1, 1'b1, 32'h80, 1'b1, 32'h300, 1'b1, 32'h200);
        tick();
        lookup("hit_retarget", 32'h80, 1'b1, 32'h300);

        drive(32'h0, 1'b1, 1'b0, 32'h84, 1'b1, 32'h400, 1'b1, 32'h0);
        tick();
        lookup("nonbranch_noalloc", 32'h84, 1'b0, 32'h0);

        for (int i = 0; i < 8; i++) begin
            drive(32'h80, vecs[i].v, vecs[i].br, 32'h300, vecs[i].tk,
                  vecs[i].tg, vecs[i].pr, vecs[i].pt);
            check($sformatf("vec%0d_outcome", i), {31'h0, predict_outcome}, {31'h0, vecs[i].exp_out});
            check($sformatf("vec%0d_bp", i), {31'h0, branch_predict}, {31'h0, m_pred(32'h80)});
            tick();
        end

`ifdef BP_STATS_EN
        check("stat_branches", stat_branches, exp_branches);
        check("stat_mispredicts", stat_mispredicts, exp_mispredicts);
`endif

        // Reset asserted while an allocating update is pending must win.
        drive(32'h0, 1'b1, 1'b1, 32'hC4, 1'b1, 32'h500, 1'b0, 32'h0);
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        m_reset();
        rst_n = 1'b1;
        lookup("rst_mid_upd", 32'hC4, 1'b0, 32'h0);
        lookup("rst_mid_old", 32'h80, 1'b0, 32'h0);

        for (int n = 0; n < 2000; n++) begin
            logic [31:0] rpc, rif;
            logic        rtk;
            rpc = {24'h0, 2'($urandom_range(3)), 4'($urandom_range(3)), 2'b00};
            rif = {24'h0, 2'($urandom_range(3)), 4'($urandom_range(3)), 2'($urandom)};
            rtk = 1'($urandom);
            if ($urandom_range(1) == 0)
                drive(rif, ($urandom_range(7) != 0), ($urandom_range(3) != 0), rpc, rtk,
                      32'h1000 + 32'($urandom_range(3)) * 4, m_pred(rpc), m_target(rpc));
            else
                drive(rif, ($urandom_range(7) != 0), ($urandom_range(3) != 0), rpc, rtk,
                      32'h1000 + 32'($urandom_range(3)) * 4, 1'($urandom),
                      32'h1000 + 32'($urandom_range(3)) * 4);
            if (n % 8 == 0) begin
                check("rnd_bp", {31'h0, branch_predict}, {31'h0, m_pred(rif)});
                check("rnd_tgt", predict_target, m_target(rif));
                check("rnd_outcome", {31'h0, predict_outcome}, {31'h0, m_outcome()});
            end else if (branch_predict !== m_pred(rif) || predict_target !== m_target(rif)
                         || predict_outcome !== m_outcome()) begin
                check("rnd_any_bp", {31'h0, branch_predict}, {31'h0, m_pred(rif)});
                check("rnd_any_tgt", predict_target, m_target(rif));
                check("rnd_any_outcome", {31'h0, predict_outcome}, {31'h0, m_outcome()});
            end
            tick();
        end

`ifdef BP_STATS_EN
        check("stat_branches_rnd", stat_branches, exp_branches);
        check("stat_mispredicts_rnd", stat_mispredicts, exp_mispredicts);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have parameter IDX_W, default 4, meaning log2 of table entries (legal 2..6; entries = 2^IDX_W).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 pc_if  input  32  PC of the instruction in IF, used for lookup.
REQ-005 branch_predict  output  1  1 = predict taken at pc_if.
REQ-006 predict_target  output  32  predicted target for pc_if; meaningful only when branch_predict=1.
REQ-007 ex_valid  input  1  a real (non-bubble) instruction occupies EX this cycle.
REQ-008 ex_is_branch  input  1  EX instruction is a conditional branch.
REQ-009 ex_pc  input  32  PC of the EX instruction.
REQ-010 ex_taken  input  1  resolved branch direction in EX.
REQ-011 ex_target  input  32  resolved branch target in EX.
REQ-012 ex_predicted  input  1  branch_predict value carried down the pipe with the EX instruction.
REQ-013 ex_pred_target  input  32  predict_target value carried down with the EX instruction.
REQ-014 predict_outcome  output  1  1 = EX prediction correct or no branch in EX; 0 = mispredict, redirect required.

Function
REQ-015 Storage SHALL be 2^IDX_W entries, each: valid bit, tag = pc[31:IDX_W+2], target[31:0], 2-bit saturating counter.
REQ-016 Index SHALL be pc[IDX_W+1:2]; pc[1:0] ignored.
REQ-017 Lookup SHALL be combinational, zero latency: hit = valid && tag match at pc_if index.
REQ-018 branch_predict SHALL be 1 iff hit && counter[1]==1; predict_target = stored target on hit, else 32'h0.
REQ-019 predict_outcome SHALL be combinational: 0 iff ex_valid && ex_is_branch && (ex_predicted != ex_taken || (ex_taken && ex_pred_target != ex_target)); otherwise 1.
REQ-020 predict_outcome SHALL be 1 whenever ex_valid=0 or ex_is_branch=0.
REQ-021 Update SHALL occur on the clock edge only when ex_valid && ex_is_branch.
REQ-022 On update with tag hit: counter increments if ex_taken (saturate at 2'b11), decrements if not taken (saturate at 2'b00); target written with ex_target when ex_taken.
REQ-023 On update with tag miss and ex_taken=1: entry allocated (replaced): valid=1, tag and target from ex_pc/ex_target, counter=2'b10.
REQ-024 On update with tag miss and ex_taken=0: no state change.
REQ-025 Lookup and update to the same index in the same cycle: lookup SHALL return pre-update contents (no bypass).
REQ-026 Non-branch EX instructions (ex_is_branch=0) SHALL never modify state, even if ex_predicted=1.

Reset
REQ-027 While rst_n=0: all valid bits 0, all counters 2'b01, tags/targets 0.
REQ-028 After reset: branch_predict=0, predict_target=32'h0 for any pc_if; predict_outcome per REQ-019/020 (combinational).
REQ-029 Reset asserted mid-update SHALL override the update; state equals REQ-027 on deassertion.

Configuration
REQ-030 Macro BP_STATS_EN defined: block SHALL add outputs stat_branches[31:0] (+1 per update event) and stat_mispredicts[31:0] (+1 per cycle with predict_outcome=0), both reset to 0, wrapping at 2^32-1 -> 0.
REQ-031 Macro BP_STATS_EN undefined: those ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-032 Reset, then pc_if=32'h0000_0040 -> branch_predict=0, predict_target=0.
REQ-033 Update ex_pc=32'h40, ex_taken=1, ex_target=32'h100, ex_predicted=0 -> predict_outcome=0 that cycle; next cycle pc_if=32'h40 -> branch_predict=1, predict_target=32'h100.
REQ-034 Same entry, two not-taken updates -> counter 2'b10->2'b01->2'b00; pc_if=32'h40 -> branch_predict=0; three taken updates -> saturates at 2'b11, predict 1.
REQ-035 Alias: entry at 32'h40 taken, then update ex_pc=32'h80 (same index, IDX_W=4) taken, target 32'h200 -> pc_if=32'h40 misses (0), pc_if=32'h80 predicts 32'h200.
REQ-036 Same-cycle lookup/update on pc 32'h40 allocating -> that cycle branch_predict=0; next cycle 1.
REQ-037 ex_predicted=1, ex_taken=1, ex_pred_target=32'h100, ex_target=32'h104 -> predict_outcome=0; with BP_STATS_EN stat_mispredicts increments by 1.
